// File: rtl/dkstr_pkg.sv
// Shared types and constants for the shortest-path engine: controller FSM states,
// weight encoding and the grid's cost/direction widths.
package dkstr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RESET,
        ST_SEED,
        ST_RUN,
        ST_DONE
    } dkstr_state_e;

    localparam logic [3:0]  WEIGHT_BLOCKED = 4'hF;
    localparam int unsigned QUIET_SWEEP    = 8;
    localparam int unsigned COST_W         = 12;
    localparam int unsigned DIR_W          = 3;

endpackage

// File: rtl/dkstr_quiet_det.sv
// Convergence/expiry detector: masked OR of the grid change flags, quiet-cycle
// counter and RUN-cycle counter with timeout compare.
module dkstr_quiet_det
    import dkstr_pkg::*;
#(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          run_en,
    input  logic [N-1:0]  path_mod,
    input  logic [N-1:0]  acc_mask,
    output logic          converged,
    output logic          expired,
    output logic [15:0]   run_cycles
);

    localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam int unsigned QW = $clog2(QUIET_SWEEP + 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic          mod_any;

    always_comb begin
        mod_any = |(path_mod & acc_mask);
        cnt_d   = cnt_q;
        quiet_d = quiet_q;
        if (clr) begin
            cnt_d   = '0;
            quiet_d = '0;
        end else if (run_en) begin
            cnt_d   = cnt_q + TW'(1);
            quiet_d = mod_any ? '0 : quiet_q + QW'(1);
        end
    end

    assign converged = run_en && (quiet_d == QW'(QUIET_SWEEP));
    assign expired   = run_en && (cnt_d == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            quiet_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            quiet_q <= quiet_d;
        end
    end

    // Internal counter may be wider than the 16-bit status port; clamp it there.
    generate
        if (TW > 16) begin : g_sat
            assign run_cycles = (|cnt_q[TW-1:16]) ? '1 : cnt_q[15:0];
        end else begin : g_direct
            assign run_cycles = cnt_q;
        end
    endgenerate

endmodule

// File: rtl/dkstr_ctl.sv
// Sequencing controller for the neu grid: weight load, grid reset, seed, relax, done.
// Optional macro DKSTR_CTL_WEIGHT_REUSE_EN adds start_reuse to skip LOAD.
module dkstr_ctl
    import dkstr_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned H       = 8,
    parameter int unsigned TIMEOUT = 4096,
    localparam int unsigned N      = W * H,
    localparam int unsigned AW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef DKSTR_CTL_WEIGHT_REUSE_EN
    input  logic          start_reuse,
`endif
    input  logic [AW-1:0] src_addr,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [3:0]    cfg_weight,
    output logic          neu_rst,
    output logic [N-1:0]  neu_clr,
    output logic [N-1:0]  neu_ld,
    output logic [3:0]    neu_ld_weight,
    input  logic [N-1:0]  neu_path_mod,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [15:0]   run_cycles
);

    dkstr_state_e  state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  ld_q, ld_d;
    logic [3:0]    wt_q, wt_d;
    logic          to_q, to_d;
    logic          accept_start;
    logic          skip_load;
    logic          converged;
    logic          expired;

`ifdef DKSTR_CTL_WEIGHT_REUSE_EN
    assign skip_load = start_reuse;
`else
    assign skip_load = 1'b0;
`endif

    assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        ld_d    = '0;
        wt_d    = wt_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_start) begin
                    src_d   = src_addr;
                    addr_d  = '0;
                    to_d    = 1'b0;
                    state_d = skip_load ? ST_RESET : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg_valid) begin
                    ld_d[addr_q]  = 1'b1;
                    wt_d          = cfg_weight;
                    acc_d[addr_q] = (cfg_weight != WEIGHT_BLOCKED);
                    addr_d        = addr_q + AW'(1);
                    if (addr_q == AW'(N - 1)) begin
                        state_d = ST_RESET;
                    end
                end
            end
            ST_RESET: state_d = ST_SEED;
            ST_SEED:  state_d = ST_RUN;
            ST_RUN: begin
                // Convergence takes priority when both land on the same cycle.
                if (converged) begin
                    state_d = ST_DONE;
                    to_d    = 1'b0;
                end else if (expired) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            ld_q    <= '0;
            wt_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            ld_q    <= ld_d;
            wt_q    <= wt_d;
            to_q    <= to_d;
        end
    end

    dkstr_quiet_det #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) u_quiet (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept_start),
        .run_en     (state_q == ST_RUN),
        .path_mod   (neu_path_mod),
        .acc_mask   (acc_q),
        .converged  (converged),
        .expired    (expired),
        .run_cycles (run_cycles)
    );

    always_comb begin
        neu_clr = '0;
        if (state_q == ST_SEED) begin
            neu_clr[src_q] = 1'b1;
        end
    end

    assign cfg_ready     = (state_q == ST_LOAD);
    assign neu_rst       = (state_q == ST_RESET);
    assign neu_ld        = ld_q;
    assign neu_ld_weight = wt_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_RESET) ||
                           (state_q == ST_SEED) || (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign timeout       = to_q;

endmodule

// File: tb/tb_dkstr_ctl.sv
// Randomised bench for dkstr_ctl on a 4x4 grid with TIMEOUT=16, driving a stub grid
// whose change flags come from a per-run-cycle pattern table.
module tb_dkstr_ctl;

    localparam int unsigned GW = 4;
    localparam int unsigned GH = 4;
    localparam int unsigned GN = GW * GH;
    localparam int         TO = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
`ifdef DKSTR_CTL_WEIGHT_REUSE_EN
    logic          start_reuse;
`endif
    logic [3:0]    src_addr;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [3:0]    cfg_weight;
    logic          neu_rst;
    logic [GN-1:0] neu_clr;
    logic [GN-1:0] neu_ld;
    logic [3:0]    neu_ld_weight;
    logic [GN-1:0] neu_path_mod;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [15:0]   run_cycles;

    int checks;
    int failures;

    logic [3:0]  wts [GN];
    logic [15:0] pat [1:TO];

    dkstr_ctl #(
        .W       (GW),
        .H       (GH),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
`ifdef DKSTR_CTL_WEIGHT_REUSE_EN
        .start_reuse   (start_reuse),
`endif
        .src_addr      (src_addr),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_weight    (cfg_weight),
        .neu_rst       (neu_rst),
        .neu_clr       (neu_clr),
        .neu_ld        (neu_ld),
        .neu_ld_weight (neu_ld_weight),
        .neu_path_mod  (neu_path_mod),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .run_cycles    (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] acc_of();
        logic [15:0] a;
        for (int i = 0; i < GN; i++) a[i] = (wts[i] != 4'hF);
        return a;
    endfunction

    task automatic gen_w(input bit randw);
        for (int i = 0; i < GN; i++) begin
            if (!randw) wts[i] = 4'h0;
            else if ($urandom_range(0, 3) == 0) wts[i] = 4'hF;
            else wts[i] = 4'($urandom_range(0, 14));
        end
    endtask

    // k: last cycle with possible accessible activity; hitk forces activity at k.
    task automatic gen_pat(input int k, input bit stuck, input bit hitk);
        logic [15:0] acc;
        acc = acc_of();
        for (int c = 1; c <= TO; c++) begin
            pat[c] = 16'($urandom) & ~acc;
            if (c <= k) pat[c] = pat[c] | 16'($urandom);
            if (stuck) pat[c] = pat[c] | 16'h0001;
            if (hitk && c == k) pat[c] = pat[c] | 16'h0001;
        end
    endtask

    // Converged at the first cycle closing an 8-cycle window with no accessible change.
    task automatic model(input logic [15:0] acc, output int e, output bit t);
        bit quiet;
        e = TO;
        t = 1'b1;
        for (int c = TO; c >= 8; c--) begin
            quiet = 1'b1;
            for (int j = c - 7; j <= c; j++)
                if ((pat[j] & acc) != 16'h0) quiet = 1'b0;
            if (quiet) begin
                e = c;
                t = 1'b0;
            end
        end
    endtask

    task automatic do_solve(input int gapmax, input bit reuse, input bit poke);
        logic [3:0] src;
        int         exp_end;
        bit         exp_to;
        int         gaps;
        src = 4'($urandom_range(0, GN - 1));
        @(negedge clk);
        start     = 1'b1;
        src_addr  = src;
        cfg_valid = 1'b0;
`ifdef DKSTR_CTL_WEIGHT_REUSE_EN
        start_reuse = reuse;
`endif
        @(negedge clk);
        start    = 1'b0;
        src_addr = 4'($urandom);
        chk("done_clr", done, 0);
        chk("to_clr", timeout, 0);
        chk("rc_clr", run_cycles, 0);
        chk("busy_start", busy, 1);
        if (!reuse) begin
            chk("ready_load", cfg_ready, 1);
            for (int i = 0; i < GN; i++) begin
                gaps = $urandom_range(0, gapmax);
                repeat (gaps) begin
                    cfg_valid    = 1'b0;
                    cfg_weight   = 4'($urandom);
                    neu_path_mod = 16'($urandom);
                    @(negedge clk);
                    chk("ld_gap", neu_ld, 0);
                end
                cfg_valid    = 1'b1;
                cfg_weight   = wts[i];
                neu_path_mod = 16'($urandom);
                @(negedge clk);
                chk("ld_hot", neu_ld, 32'(1) << i);
                chk("ld_wt", neu_ld_weight, wts[i]);
            end
            cfg_valid = 1'b0;
        end else begin
            chk("reuse_no_ld", neu_ld, 0);
        end
        chk("rst_pulse", neu_rst, 1);
        chk("ready_off", cfg_ready, 0);
        @(negedge clk);
        chk("rst_once", neu_rst, 0);
        chk("clr_hot", neu_clr, 32'(1) << src);
        chk("ld_quiet", neu_ld, 0);
        neu_path_mod = '1;
        model(acc_of(), exp_end, exp_to);
        for (int c = 1; c <= exp_end; c++) begin
            @(negedge clk);
            chk("run_busy", busy, 1);
            chk("run_cnt", run_cycles, c - 1);
            chk("run_nodone", done, 0);
            if (c == 1) chk("clr_once", neu_clr, 0);
            neu_path_mod = pat[c];
            start        = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            src_addr     = 4'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done", done, 1);
        chk("timeout", timeout, exp_to);
        chk("run_final", run_cycles, exp_end);
        chk("busy_done", busy, 0);
        neu_path_mod = 16'($urandom);
        repeat (2) @(negedge clk);
        chk("done_hold", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        src_addr     = '0;
        cfg_valid    = 1'b0;
        cfg_weight   = '0;
        neu_path_mod = '0;
`ifdef DKSTR_CTL_WEIGHT_REUSE_EN
        start_reuse  = 1'b0;
`endif
        #12;
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ld", neu_ld, 0);
        chk("rst_rc", run_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", cfg_ready, 0);

        // All weights open, grid silent: minimum-latency convergence.
        gen_w(1'b0);
        gen_pat(0, 1'b0, 1'b0);
        do_solve(0, 1'b0, 1'b0);

        // Blocked node 5 keeps toggling; only early accessible activity.
        gen_w(1'b1);
        wts[5] = 4'hF;
        gen_pat(3, 1'b0, 1'b0);
        for (int c = 1; c <= TO; c++) pat[c] = pat[c] | 16'h0020;
        do_solve(3, 1'b0, 1'b0);

        // Node 0 stuck changing: timeout at TIMEOUT.
        gen_w(1'b0);
        gen_pat(0, 1'b1, 1'b0);
        do_solve(2, 1'b0, 1'b1);

        // Convergence and timeout on the same cycle: convergence wins.
        gen_w(1'b0);
        gen_pat(8, 1'b0, 1'b1);
        do_solve(1, 1'b0, 1'b0);

        // One cycle later: timeout.
        gen_w(1'b0);
        gen_pat(9, 1'b0, 1'b1);
        do_solve(1, 1'b0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            gen_w(1'b1);
            wts[0] = 4'h2;
            gen_pat($urandom_range(0, 10), 1'b0, 1'($urandom_range(0, 1)));
            do_solve(3, 1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef DKSTR_CTL_WEIGHT_REUSE_EN
        gen_pat($urandom_range(0, 6), 1'b0, 1'b0);
        do_solve(0, 1'b1, 1'b0);
        start_reuse = 1'b0;
`endif

        // Asynchronous reset during LOAD.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cfg_valid  = 1'b1;
        cfg_weight = 4'h9;
        @(negedge clk);
        chk("mid_ld_wt", neu_ld_weight, 4'h9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", cfg_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ld", neu_ld, 0);
        chk("arst_wt", neu_ld_weight, 0);
        chk("arst_rst", neu_rst, 0);
        chk("arst_done", done, 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", cfg_ready, 0);
        chk("arst_idle_busy", busy, 0);

        gen_w(1'b1);
        gen_pat(2, 1'b0, 1'b0);
        do_solve(2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
